// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and data access.
// Optional MEM_ARB_TIMEOUT_EN adds an ack watchdog that ends a hung cycle and pulses err_o.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ce_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic [DATA_W-1:0]   i_data_o,
    output logic                i_stall_o,
    input  logic                d_ce_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_data_i,
    output logic [DATA_W-1:0]   d_data_o,
    output logic                d_stall_o,
    output logic                m_ce_o,
    output logic                m_we_o,
    output logic [DATA_W/8-1:0] m_sel_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_data_o,
    input  logic [DATA_W-1:0]   m_data_i,
    input  logic                m_ack_i,
    output logic                err_o
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_i_done;
    logic                r_d_done;
    logic                w_tmo;
    logic                w_end;
    logic [DATA_W-1:0]   w_rdata;

    assign w_end     = m_ack_i | w_tmo;
    assign w_rdata   = w_tmo ? {DATA_W{1'b0}} : m_data_i;
    assign i_stall_o = i_ce_i & ~r_i_done;
    assign d_stall_o = d_ce_i & ~r_d_done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_err;

    // A cycle times out on the wait cycle where the count reaches TIMEOUT without an ack.
    assign w_tmo = ((r_state == D_ACC) || (r_state == I_ACC)) && !m_ack_i &&
                   (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign err_o = r_err;

    // Wait-cycle counter, cleared outside an access, plus the registered error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= {CNT_W{1'b0}};
            r_err     <= 1'b0;
        end else begin
            r_err <= w_tmo;
            if (((r_state == D_ACC) || (r_state == I_ACC)) && !w_end) begin
                r_tmo_cnt <= r_tmo_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_tmo_cnt <= {CNT_W{1'b0}};
            end
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err_o = 1'b0;
`endif

    // Grant FSM: data wins ties, m_* held for the whole access, DONE blocks a stale re-grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            m_ce_o   <= 1'b0;
            m_we_o   <= 1'b0;
            m_sel_o  <= {SEL_W{1'b0}};
            m_addr_o <= {ADDR_W{1'b0}};
            m_data_o <= {DATA_W{1'b0}};
            i_data_o <= {DATA_W{1'b0}};
            d_data_o <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    if (d_ce_i) begin
                        m_ce_o   <= 1'b1;
                        m_we_o   <= d_we_i;
                        m_sel_o  <= d_sel_i;
                        m_addr_o <= d_addr_i;
                        m_data_o <= d_data_i;
                        r_state  <= D_ACC;
                    end else if (i_ce_i) begin
                        m_ce_o   <= 1'b1;
                        m_we_o   <= 1'b0;
                        m_sel_o  <= {SEL_W{1'b1}};
                        m_addr_o <= i_addr_i;
                        m_data_o <= {DATA_W{1'b0}};
                        r_state  <= I_ACC;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                D_ACC: begin
                    if (w_end) begin
                        if (!m_we_o) begin
                            d_data_o <= w_rdata;
                        end
                        r_d_done <= 1'b1;
                        m_ce_o   <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                I_ACC: begin
                    if (w_end) begin
                        i_data_o <= w_rdata;
                        r_i_done <= 1'b1;
                        m_ce_o   <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    m_ce_o   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected read-back words,
// a negedge monitor compares them whenever a requester sees its stall released.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_ce_i = 1'b0;
    logic [31:0] i_addr_i = 32'h0;
    logic [31:0] i_data_o;
    logic        i_stall_o;
    logic        d_ce_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [3:0]  d_sel_i = 4'h0;
    logic [31:0] d_addr_i = 32'h0;
    logic [31:0] d_data_i = 32'h0;
    logic [31:0] d_data_o;
    logic        d_stall_o;
    logic        m_ce_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [31:0] m_data_i = 32'h0;
    logic        m_ack_i = 1'b0;
    logic        err_o;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] d_last = 32'h0;
    int          t;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_ce_i(i_ce_i), .i_addr_i(i_addr_i), .i_data_o(i_data_o), .i_stall_o(i_stall_o),
        .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
        .d_data_i(d_data_i), .d_data_o(d_data_o), .d_stall_o(d_stall_o),
        .m_ce_o(m_ce_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_addr_o(m_addr_o),
        .m_data_o(m_data_o), .m_data_i(m_data_i), .m_ack_i(m_ack_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the grant, checks m_* against the expected request, holds them until the ack.
    task automatic serve(input logic ewe, input logic [3:0] esel, input logic [31:0] eaddr,
                         input logic [31:0] ewd, input logic [31:0] rdata,
                         input int ack_cyc, output int ticks);
        logic [69:0] exp_m;
        exp_m = {1'b1, ewe, esel, eaddr, ewd};
        ticks = 0;
        while (!m_ce_o && ticks < 20) begin
            tick();
            ticks++;
        end
        chk("grant", {m_ce_o, m_we_o, m_sel_o, m_addr_o, m_data_o}, exp_m);
        for (int k = 1; k < ack_cyc; k++) begin
            tick();
            ticks++;
            chk("hold", {m_ce_o, m_we_o, m_sel_o, m_addr_o, m_data_o}, exp_m);
        end
        m_ack_i = 1'b1;
        m_data_i = rdata;
        tick();
        ticks++;
        m_ack_i = 1'b0;
        m_data_i = 32'hA5A5_A5A5;
    endtask

    // Single request on one port, served with an ack on the ack_cyc-th memory cycle.
    task automatic access(input bit is_d, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int ack_cyc);
        int tk;
        if (is_d) begin
            d_ce_i = 1'b1; d_we_i = we; d_sel_i = sel; d_addr_i = addr; d_data_i = wd;
            if (!we) d_last = rdata;
            dq.push_back(d_last);
            serve(we, sel, addr, wd, rdata, ack_cyc, tk);
            chk("d_stall_len", 70'(tk), 70'(1 + ack_cyc));
            chk("d_stall_end", 70'(d_stall_o), 70'(0));
        end else begin
            i_ce_i = 1'b1; i_addr_i = addr;
            iq.push_back(rdata);
            serve(1'b0, 4'hF, addr, 32'h0, rdata, ack_cyc, tk);
            chk("i_stall_len", 70'(tk), 70'(1 + ack_cyc));
            chk("i_stall_end", 70'(i_stall_o), 70'(0));
        end
        tick();
        i_ce_i = 1'b0;
        d_ce_i = 1'b0;
    endtask

    // Monitor: a requester whose stall is released with ce high consumes the next expected word.
    always @(negedge clk) begin
        if (rst) begin
            if (i_ce_i && !i_stall_o) begin
                if (iq.size() == 0) chk("i_unexpected", 70'(1), 70'(0));
                else chk("i_data", 70'(i_data_o), 70'(iq.pop_front()));
            end
            if (d_ce_i && !d_stall_o) begin
                if (dq.size() == 0) chk("d_unexpected", 70'(1), 70'(0));
                else chk("d_data", 70'(d_data_o), 70'(dq.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("reset_out", {m_ce_o, m_we_o, m_sel_o, m_addr_o, m_data_o},  70'h0);
        chk("reset_data", {5'h0, i_data_o, d_data_o, err_o}, 70'h0);
        rst = 1'b1;
        tick();

        // Fetch only
        access(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h3C01_0001, 1);

        // Data and fetch in the same cycle: data first, fetch held stalled
        d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h200; d_data_i = 32'h0;
        i_ce_i = 1'b1; i_addr_i = 32'h104;
        d_last = 32'h1111_2222;
        dq.push_back(32'h1111_2222);
        iq.push_back(32'h3333_4444);
        serve(1'b0, 4'hF, 32'h200, 32'h0, 32'h1111_2222, 1, t);
        chk("both_d_len", 70'(t), 70'(2));
        chk("both_stalls", {68'h0, d_stall_o, i_stall_o}, 70'b01);
        tick();
        d_ce_i = 1'b0;
        chk("both_i_held", 70'(i_stall_o), 70'(1));
        serve(1'b0, 4'hF, 32'h104, 32'h0, 32'h3333_4444, 1, t);
        chk("both_i_len", 70'(t), 70'(2));
        chk("both_i_end", 70'(i_stall_o), 70'(0));
        tick();
        i_ce_i = 1'b0;

        // Store: read-back register must keep the last read value
        access(1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 32'h1234_5678, 2);
        chk("store_keep", 70'(d_data_o), 70'(32'h1111_2222));

        // Slow ack, then a spurious ack while idle
        access(1'b0, 1'b0, 4'hF, 32'h108, 32'h0, 32'h0BAD_F00D, 5);
        m_ack_i = 1'b1; m_data_i = 32'hFFFF_0000;
        tick();
        m_ack_i = 1'b0;
        tick();
        chk("spurious", {37'h0, m_ce_o, i_data_o}, {37'h0, 1'b0, 32'h0BAD_F00D});
        chk("spurious_d", 70'(d_data_o), 70'(32'h1111_2222));

        // Flush: requester drops ce mid-access, the read still lands
        d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h300;
        tick();
        d_ce_i = 1'b0;
        tick();
        m_ack_i = 1'b1; m_data_i = 32'hCAFE_0300;
        tick();
        m_ack_i = 1'b0;
        d_last = 32'hCAFE_0300;
        chk("flush", {36'h0, m_ce_o, d_stall_o, d_data_o}, {36'h0, 2'b00, 32'hCAFE_0300});
        tick();

        // Reset in the middle of a data access
        d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h500; d_data_i = 32'h0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_abort", {36'h0, m_ce_o, d_stall_o, d_data_o}, {36'h0, 2'b01, 32'h0});
        d_last = 32'h0;
        tick();
        tick();
        rst = 1'b1;
        d_last = 32'h5555_0500;
        dq.push_back(32'h5555_0500);
        serve(1'b0, 4'hF, 32'h500, 32'h0, 32'h5555_0500, 1, t);
        chk("regrant_len", 70'(t), 70'(2));
        tick();
        d_ce_i = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack ever: the watchdog ends the read with zero data and an error pulse
        d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h600;
        dq.push_back(32'h0);
        t = 0;
        while (d_stall_o && t < 20) begin
            tick();
            t++;
        end
        chk("tmo_len", 70'(t), 70'(TMO + 1));
        chk("tmo_err", {68'h0, err_o, d_stall_o}, 70'b10);
        tick();
        d_ce_i = 1'b0;
        chk("tmo_err_pulse", 70'(err_o), 70'(0));
`else
        chk("err_tied", 70'(err_o), 70'(0));
`endif

        tick();
        chk("iq_drained", 70'(iq.size()), 70'(0));
        chk("dq_drained", 70'(dq.size()), 70'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
